// File: rtl/mux5_pkg.sv
// Shared slot encoding and state type for the 5:1 nibble multiplexer and
// its 1:5 distributor counterpart.
package mux5_pkg;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_A = 3'd0;
  localparam slot_t SLOT_B = 3'd1;
  localparam slot_t SLOT_C = 3'd2;
  localparam slot_t SLOT_D = 3'd3;
  localparam slot_t SLOT_E = 3'd4;
  localparam int    NSLOTS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } demux_state_t;

endpackage

// File: rtl/nibble_demux5.sv
// Round-robin 1:5 nibble distributor with double-buffered frame outputs.
// Partial frames live in shadow registers and reach A..E only at commit.
module nibble_demux5
  import mux5_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             valid,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output slot_t            slot,
  output logic             done,
  output logic [7:0]       frames,
  output demux_state_t     state_dbg
);

  // Handshake: 'in' is consumed on every rising edge where valid=1; there is
  // no backpressure, so the source may stream one nibble per cycle.

  demux_state_t     state, state_next;
  slot_t            slot_next;
  logic             shadow_we;
  logic [1:0]       shadow_idx;
  logic             commit;
  logic [WIDTH-1:0] shadow [4];

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      slot  <= SLOT_A;
    end else begin
      state <= state_next;
      slot  <= slot_next;
    end
  end

  always_comb begin
    state_next = state;
    slot_next  = slot;
    shadow_we  = 1'b0;
    shadow_idx = slot[1:0];
    commit     = 1'b0;
    if (slot > SLOT_E) begin
      // Illegal pointer: recover unconditionally, dropping whatever was held.
      slot_next  = SLOT_A;
      state_next = IDLE;
    end else if (start) begin
      // Frame sync outranks a pending commit.
      if (valid) begin
        shadow_we  = 1'b1;
        shadow_idx = 2'd0;
        slot_next  = SLOT_B;
        state_next = FILL;
      end else begin
        slot_next  = SLOT_A;
        state_next = IDLE;
      end
    end else if (valid) begin
      if (slot == SLOT_E) begin
        commit     = 1'b1;
        slot_next  = SLOT_A;
        state_next = IDLE;
      end else begin
        shadow_we  = 1'b1;
        slot_next  = slot + 3'd1;
        state_next = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      A      <= '0;
      B      <= '0;
      C      <= '0;
      D      <= '0;
      E      <= '0;
      done   <= 1'b0;
      frames <= 8'd0;
    end else begin
      done <= commit;
      if (shadow_we) shadow[shadow_idx] <= in;
      if (commit) begin
        // Slot E bypasses the shadows: it is the nibble arriving at commit.
        A      <= shadow[0];
        B      <= shadow[1];
        C      <= shadow[2];
        D      <= shadow[3];
        E      <= in;
        frames <= frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_demux5.sv
// Bench for nibble_demux5: directed frame scenarios plus random traffic,
// checked against a queue-based frame model and a done-driven scoreboard.
module tb_nibble_demux5;
  import mux5_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   din = '0;
  logic         valid = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   A, B, C, D, E;
  slot_t        slot;
  logic         done;
  logic [7:0]   frames;
  demux_state_t state_dbg;

  nibble_demux5 #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in(din), .valid(valid), .start(start),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .slot(slot), .done(done), .frames(frames), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  logic [27:0] exp_q[$];
  logic [3:0]  part[$];
  logic [19:0] cur_frame = '0;
  int exp_frames = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int done_cnt = 0;
  bit gap_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is simply the list of nibbles collected since
  // the last sync/commit; the fifth one closes it.
  task automatic model(input logic v, input logic s, input logic [3:0] d);
    if (s && v) begin
      part.delete();
      part.push_back(d);
    end else if (s) begin
      part.delete();
    end else if (v) begin
      if (part.size() == NSLOTS - 1) begin
        cur_frame = {part[0], part[1], part[2], part[3], d};
        exp_frames = (exp_frames + 1) % 256;
        exp_q.push_back({cur_frame, exp_frames[7:0]});
        part.delete();
      end else begin
        part.push_back(d);
      end
    end
  endtask

  task automatic model_reset();
    part.delete();
    cur_frame = '0;
    exp_frames = 0;
  endtask

  task automatic step(input logic v, input logic s, input logic [3:0] d);
    valid = v;
    start = s;
    din = d;
    @(posedge clk);
    model(v, s, d);
    #1;
    check("slot", 32'(slot), 32'(part.size()));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every done pulse pops one expected frame.
  always @(negedge clk) begin
    cyc++;
    if (!reset && done) begin
      check("done_not_back_to_back", 32'(cyc - last_done_cyc > 1), 32'd1);
      if (gap_chk && last_done_cyc >= 0)
        check("done_gap", 32'(cyc - last_done_cyc), 32'd5);
      last_done_cyc = cyc;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("frame", 32'({A, B, C, D, E, frames}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({A, B, C, D, E, frames, slot, done}), 32'd0);
    reset = 1'b0;

    // Frame load
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 4'(i));
    check("load_frame", 32'({A, B, C, D, E}), 32'h12345);
    check("load_done", 32'(done), 32'd1);
    check("load_frames", 32'(frames), 32'd1);
    step(1'b0, 1'b0, 4'h0);
    check("load_done_drop", 32'(done), 32'd0);

    // Holding a partial frame
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'h8);
    step(1'b1, 1'b0, 4'h7);
    repeat (10) step(1'b0, 1'b0, 4'(($urandom_range(0, 15))));
    check("hold_slot", 32'(slot), 32'd3);
    check("hold_frame", 32'({A, B, C, D, E}), 32'h12345);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'h5);
    check("hold_commit", 32'({A, B, C, D, E}), 32'h98765);

    // Resync at slot 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 1));
    step(1'b1, 1'b1, 4'hF);
    check("resync_nodone", 32'(done), 32'd0);
    check("resync_keep", 32'({A, B, C, D, E}), 32'h98765);
    repeat (4) step(1'b1, 1'b0, 4'hA);
    check("resync_frame", 32'({A, B, C, D, E}), 32'hFAAAA);

    // Start beats commit at slot 4
    repeat (4) step(1'b1, 1'b0, 4'h3);
    check("sbc_slot4", 32'(slot), 32'd4);
    step(1'b1, 1'b1, 4'h2);
    check("sbc_slot", 32'(slot), 32'd1);
    check("sbc_nodone", 32'(done), 32'd0);
    check("sbc_frame", 32'({A, B, C, D, E}), 32'hFAAAA);
    repeat (4) step(1'b1, 1'b0, 4'h7);
    check("sbc_next_frame", 32'({A, B, C, D, E}), 32'h27777);

    // Start without valid discards the partial frame
    repeat (2) step(1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b1, 4'h0);
    check("start_novalid_slot", 32'(slot), 32'd0);

    // Asynchronous reset mid-cycle with slot=2
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h4);
    valid = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_outputs", 32'({A, B, C, D, E, frames, slot, done}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) step(1'b1, 1'b0, 4'hC);
    check("post_reset_frame", 32'({A, B, C, D, E}), 32'hCCCCC);
    check("post_reset_frames", 32'(frames), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
           4'($urandom_range(0, 15)));
      check("rand_frame_hold", 32'({A, B, C, D, E}), 32'(cur_frame));
    end

    // Counter wrap over 256 back-to-back frames
    do_reset();
    done_cnt = 0;
    last_done_cyc = -100;
    gap_chk = 1'b1;
    for (int i = 0; i < 256 * NSLOTS; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    step(1'b0, 1'b0, 4'h0);
    gap_chk = 1'b0;
    check("wrap_frames", 32'(frames), 32'd0);
    check("wrap_done_count", 32'(done_cnt), 32'd256);

    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
